// File: rtl/serial_add_sequencer.sv
// serial_add_sequencer: bit-serial adder controller; one shared 1-bit adder cell stepped LSB first, one bit per clock.
// Optional build macro SERIAL_ADD_SUB_EN adds a Sub input selecting two's-complement subtraction A-B.
module serial_add_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             Start,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             Sub,
`endif
   input  logic [WIDTH-1:0] OperandA,
   input  logic [WIDTH-1:0] OperandB,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Result,
   output logic             CarryOut
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             sub_in;
   logic             ha1_s, ha1_c, ha2_s, ha2_c, cell_cout;

`ifdef SERIAL_ADD_SUB_EN
   assign sub_in = Sub;
`else
   assign sub_in = 1'b0;
`endif

   // single full-adder cell built from two half adders and an OR for the carry
   always_comb begin
      ha1_s     = a_sr_q[0] ^ b_sr_q[0];
      ha1_c     = a_sr_q[0] & b_sr_q[0];
      ha2_s     = ha1_s ^ carry_q;
      ha2_c     = ha1_s & carry_q;
      cell_cout = ha1_c | ha2_c;
   end

   // next-state and datapath: load on accept, shift one bit per RUN cycle, publish result on the last bit
   always_comb begin
      state_d  = state_q;
      a_sr_d   = a_sr_q;
      b_sr_d   = b_sr_q;
      sum_d    = sum_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      cout_d   = cout_q;
      case (state_q)
         S_IDLE: begin
            if (Start) begin
               a_sr_d  = OperandA;
               b_sr_d  = sub_in ? ~OperandB : OperandB;
               carry_d = sub_in;
               sum_d   = '0;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            a_sr_d  = a_sr_q >> 1;
            b_sr_d  = b_sr_q >> 1;
            sum_d   = {ha2_s, sum_q[WIDTH-1:1]};
            carry_d = cell_cout;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d  = S_DONE;
               result_d = {ha2_s, sum_q[WIDTH-1:1]};
               cout_d   = cell_cout;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // state and datapath registers, cleared asynchronously
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q  <= S_IDLE;
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         sum_q    <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sr_q   <= a_sr_d;
         b_sr_q   <= b_sr_d;
         sum_q    <= sum_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         cout_q   <= cout_d;
      end
   end

   assign Busy     = (state_q != S_IDLE);
   assign Done     = (state_q == S_DONE);
   assign Result   = result_q;
   assign CarryOut = cout_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// tb_serial_add_sequencer: directed bench with an arithmetic reference model checked every cycle.
module tb_serial_add_sequencer;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         sub = 1'b0;
   logic [W-1:0] oa = '0;
   logic [W-1:0] ob = '0;
   logic         busy, done, cout;
   logic [W-1:0] res;
   logic         sub_eff;
   int           total = 0;
   int           bad = 0;

   always #5 clk = ~clk;

`ifdef SERIAL_ADD_SUB_EN
   assign sub_eff = sub;
`else
   assign sub_eff = 1'b0;
`endif

   serial_add_sequencer #(.WIDTH(W)) dut (
      .Clk(clk),
      .Rst_n(rst_n),
      .Start(start),
`ifdef SERIAL_ADD_SUB_EN
      .Sub(sub),
`endif
      .OperandA(oa),
      .OperandB(ob),
      .Busy(busy),
      .Done(done),
      .Result(res),
      .CarryOut(cout)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   int       m_left = 0;
   logic [W:0]   m_pend = '0;
   logic [W-1:0] m_res = '0;
   logic         m_c = 1'b0;

   // reference: an accepted op keeps the block busy W+1 cycles and publishes A+B (or A-B) in its last one
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_left <= 0;
         m_pend <= '0;
         m_res  <= '0;
         m_c    <= 1'b0;
      end else if (m_left == 0) begin
         if (start) begin
            m_left <= W + 1;
            m_pend <= sub_eff ? ({1'b0, oa} + {1'b0, ~ob} + 9'd1) : ({1'b0, oa} + {1'b0, ob});
         end
      end else begin
         m_left <= m_left - 1;
         if (m_left == 2) {m_c, m_res} <= m_pend;
      end
   end

   // every-cycle comparison against the reference
   always @(negedge clk) begin
      chk("busy", busy, m_left != 0);
      chk("done", done, m_left == 1);
      chk("result", res, m_res);
      chk("carry", cout, m_c);
   end

   task automatic fin(input logic [W-1:0] er, input logic ec, input int en, input string nm);
      int n = 0;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_lat"}, n, en);
      chk({nm, "_res"}, res, er);
      chk({nm, "_co"}, cout, ec);
      @(negedge clk);
      chk({nm, "_idle"}, busy, 0);
   endtask

   task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                     input logic [W-1:0] er, input logic ec, input string nm);
      @(negedge clk);
      oa = a;
      ob = b;
      sub = s;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      fin(er, ec, W, nm);
   endtask

   int dt[$];

   initial begin
      start = 1'b1;
      oa = 8'h21;
      ob = 8'h12;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_res", res, 8'h00);
      chk("rst_co", cout, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("accept_after_rst", busy, 1);
      start = 1'b0;
      fin(8'h33, 1'b0, W, "first");

      op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "basic");
      op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "wrap");
      op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "zero");

      @(negedge clk);
      oa = 8'h5A;
      ob = 8'h3C;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      oa = 8'h11;
      ob = 8'h22;
      start = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b0;
      fin(8'h96, 1'b0, W - 4, "ignore");

      @(negedge clk);
      oa = 8'h01;
      ob = 8'h01;
      start = 1'b1;
      for (int i = 1; i <= 35; i++) begin
         @(negedge clk);
         if (done) dt.push_back(i);
      end
      start = 1'b0;
      chk("bb_pulses", dt.size(), 3);
      if (dt.size() == 3) begin
         chk("bb_first", dt[0], W + 1);
         chk("bb_gap1", dt[1] - dt[0], W + 2);
         chk("bb_gap2", dt[2] - dt[1], W + 2);
      end
      chk("bb_res", res, 8'h02);
      repeat (12) @(negedge clk);
      chk("bb_idle", busy, 0);

      @(negedge clk);
      oa = 8'hAA;
      ob = 8'h55;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_res", res, 8'h00);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, "after_abort");

`ifdef SERIAL_ADD_SUB_EN
      op(8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, "sub_pos");
      op(8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, "sub_neg");
      sub = 1'b0;
`endif

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
